datapath_with_instructions: RTL and testbench

//   Single-cycle RV64-style load/store datapath: PC, instruction memory, 32x64 register file,
//   add/sub ALU (ULA), data memory. Register indices come from the fetched instruction.

---
 rtl/datapath_with_instructions.sv | 98 +++++++++
 tb/tb_datapath_with_instructions.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_with_instructions.sv
// ============================================================================
// Module  : datapath_with_instructions
// Brief   : Single-cycle RV64-style load/store datapath (PC, IMEM, RF, ALU, DMEM)
// Revision: 1.0
// ============================================================================
`default_nettype none

module datapath_with_instructions #(
    parameter int    XLEN       = 64,
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "imem.hex",
    parameter string DMEM_FILE  = "dmem.hex"
) (
    input  logic            CLK,
    input  logic            reset_pc,
    input  logic            load_pc,
    input  logic [11:0]     immediate,
    input  logic            sub,
    input  logic            ULA_din2_sel,
    input  logic            RF_din_sel,
    input  logic            WE_RF,
    input  logic            WE_MEM,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    output logic [XLEN-1:0] alu_result
);

    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [31:0]     imem_q [IMEM_DEPTH];
    logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
    // x0 has no storage; its reads are forced to zero below.
    logic [XLEN-1:0] rf_q   [1:31];

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm64;
    logic [XLEN-1:0] din2;
    logic [DA_W-1:0] dmem_idx;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] rf_wdata;
    logic            w_unused_bits;

    always_comb begin
        pc_d = pc_q;
        if (load_pc) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset_pc) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc          = pc_q;
    assign instruction = imem_q[pc_q[IA_W+1:2]];

    assign rs1 = instruction[19:15];
    assign rs2 = instruction[24:20];
    assign rd  = instruction[11:7];

    assign w_unused_bits = ^{instruction[31:25], instruction[14:12], instruction[6:0]};

    assign rs1_data = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    assign imm64      = {{(XLEN-12){immediate[11]}}, immediate};
    assign din2       = ULA_din2_sel ? imm64 : rs2_data;
    assign alu_result = sub ? (rs1_data - din2) : (rs1_data + din2);

    // Upper address bits are dropped, so data addresses wrap around the array.
    assign dmem_idx   = alu_result[DA_W-1:0];
    assign dmem_rdata = dmem_q[dmem_idx];
    assign rf_wdata   = RF_din_sel ? alu_result : dmem_rdata;

    always_ff @(posedge CLK) begin
        if (WE_RF && (rd != 5'd0)) begin
            rf_q[rd] <= rf_wdata;
        end
        if (WE_MEM) begin
            dmem_q[dmem_idx] <= rs2_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_datapath_with_instructions.sv
// ============================================================================
// Module  : tb_datapath_with_instructions
// Brief   : Directed program with a queue-based scoreboard for the datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_datapath_with_instructions;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [4:0]  c;      // {sub, din2_sel, rf_din_sel, we_rf, we_mem}
    logic [63:0] alu;
  } op_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] alu;
  } exp_t;

  localparam logic [4:0] C_ADDI  = 5'b01110;
  localparam logic [4:0] C_ST    = 5'b01001;
  localparam logic [4:0] C_LD    = 5'b01010;
  localparam logic [4:0] C_ADD   = 5'b00110;
  localparam logic [4:0] C_SUB   = 5'b10110;
  localparam logic [4:0] C_PEEK  = 5'b00100;
  localparam logic [4:0] C_DUAL  = 5'b01111;
  localparam logic [4:0] C_SUBIP = 5'b11100;
  localparam logic [4:0] C_SUBP  = 5'b10100;
  localparam int         NPROG   = 36;

  logic        CLK = 1'b0;
  logic        reset_pc;
  logic        load_pc;
  logic [11:0] immediate;
  logic        sub;
  logic        ULA_din2_sel;
  logic        RF_din_sel;
  logic        WE_RF;
  logic        WE_MEM;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [63:0] alu_result;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q [$];
  logic [63:0] exp_pc;
  op_t         prog [NPROG];

  datapath_with_instructions #(
    .XLEN(64), .IMEM_DEPTH(256), .DMEM_DEPTH(256), .IMEM_FILE(""), .DMEM_FILE("")
  ) dut (
    .CLK(CLK), .reset_pc(reset_pc), .load_pc(load_pc), .immediate(immediate),
    .sub(sub), .ULA_din2_sel(ULA_din2_sel), .RF_din_sel(RF_din_sel),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .pc(pc), .instruction(instruction),
    .alu_result(alu_result)
  );

  always #5 CLK = ~CLK;

  function automatic op_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [11:0] imm, input logic [4:0] c, input logic [63:0] alu);
    op_t o;
    o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.c = c; o.alu = alu;
    return o;
  endfunction

  // Opcode/funct fields are filled with non-zero junk the datapath must ignore.
  function automatic logic [31:0] enc(input op_t o);
    return {7'b0100000, o.rs2, o.rs1, 3'b011, o.rd, 7'b0110011};
  endfunction

  function automatic op_t nowrite(input op_t o);
    op_t r;
    r = o;
    r.c[1:0] = 2'b00;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input op_t o, input logic ldpc, input logic rst);
    exp_t e;
    @(posedge CLK);
    #1;
    reset_pc     = rst;
    load_pc      = ldpc;
    immediate    = o.imm;
    sub          = o.c[4];
    ULA_din2_sel = o.c[3];
    RF_din_sel   = o.c[2];
    WE_RF        = o.c[1];
    WE_MEM       = o.c[0];
    e.pc  = exp_pc;
    e.ins = enc(o);
    e.alu = o.alu;
    exp_q.push_back(e);
    if (rst) exp_pc = 64'd0;
    else if (ldpc) exp_pc = exp_pc + 64'd4;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("instruction", 64'(instruction), 64'(e.ins));
      chk("alu_result", alu_result, e.alu);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_pc = 1'b1; load_pc = 1'b0; immediate = 12'd0; sub = 1'b0;
    ULA_din2_sel = 1'b0; RF_din_sel = 1'b0; WE_RF = 1'b0; WE_MEM = 1'b0;
    exp_pc = 64'd0;

    prog[0]  = mk(5'd3,  5'd0,  5'd0,  12'd7,   C_ADDI,  64'd7);
    prog[1]  = mk(5'd4,  5'd0,  5'd0,  12'd12,  C_ADDI,  64'd12);
    prog[2]  = mk(5'd0,  5'd0,  5'd3,  12'd16,  C_ST,    64'd16);
    prog[3]  = mk(5'd0,  5'd0,  5'd4,  12'd21,  C_ST,    64'd21);
    prog[4]  = mk(5'd2,  5'd0,  5'd0,  12'd500, C_ADDI,  64'd500);
    prog[5]  = mk(5'd0,  5'd0,  5'd2,  12'd30,  C_ST,    64'd30);
    prog[6]  = mk(5'd1,  5'd0,  5'd0,  12'd16,  C_LD,    64'd16);
    prog[7]  = mk(5'd5,  5'd0,  5'd0,  12'd21,  C_LD,    64'd21);
    prog[8]  = mk(5'd10, 5'd1,  5'd5,  12'd0,   C_ADD,   64'd19);
    prog[9]  = mk(5'd20, 5'd5,  5'd1,  12'd0,   C_SUB,   64'd5);
    prog[10] = mk(5'd0,  5'd0,  5'd10, 12'd10,  C_ST,    64'd10);
    prog[11] = mk(5'd0,  5'd0,  5'd20, 12'd11,  C_ST,    64'd11);
    prog[12] = mk(5'd12, 5'd0,  5'd0,  12'd10,  C_LD,    64'd10);
    prog[13] = mk(5'd13, 5'd0,  5'd0,  12'd11,  C_LD,    64'd11);
    prog[14] = mk(5'd0,  5'd12, 5'd0,  12'd0,   C_PEEK,  64'd19);
    prog[15] = mk(5'd0,  5'd13, 5'd0,  12'd0,   C_PEEK,  64'd5);
    prog[16] = mk(5'd20, 5'd20, 5'd0,  12'd45,  C_ADDI,  64'd50);
    prog[17] = mk(5'd21, 5'd0,  5'd0,  12'd30,  C_LD,    64'd30);
    prog[18] = mk(5'd30, 5'd21, 5'd0,  12'hE6F, C_ADDI,  64'd99);
    prog[19] = mk(5'd0,  5'd20, 5'd0,  12'd0,   C_PEEK,  64'd50);
    prog[20] = mk(5'd0,  5'd30, 5'd0,  12'd0,   C_PEEK,  64'd99);
    prog[21] = mk(5'd0,  5'd0,  5'd0,  12'd123, C_ADDI,  64'd123);
    prog[22] = mk(5'd0,  5'd0,  5'd0,  12'd0,   C_PEEK,  64'd0);
    prog[23] = mk(5'd0,  5'd0,  5'd3,  12'h103, C_ST,    64'd259);
    prog[24] = mk(5'd22, 5'd0,  5'd0,  12'h103, C_LD,    64'd259);
    prog[25] = mk(5'd0,  5'd22, 5'd0,  12'd0,   C_PEEK,  64'd7);
    prog[26] = mk(5'd15, 5'd0,  5'd0,  12'hFFF, C_ADDI,  64'hFFFF_FFFF_FFFF_FFFF);
    prog[27] = mk(5'd16, 5'd15, 5'd0,  12'd1,   C_ADDI,  64'd0);
    prog[28] = mk(5'd0,  5'd16, 5'd0,  12'd0,   C_PEEK,  64'd0);
    prog[29] = mk(5'd17, 5'd0,  5'd3,  12'd40,  C_DUAL,  64'd40);
    prog[30] = mk(5'd18, 5'd0,  5'd0,  12'd40,  C_LD,    64'd40);
    prog[31] = mk(5'd0,  5'd18, 5'd17, 12'd0,   C_PEEK,  64'd47);
    prog[32] = mk(5'd22, 5'd22, 5'd0,  12'd1,   C_ADDI,  64'd8);
    prog[33] = mk(5'd0,  5'd22, 5'd0,  12'd0,   C_PEEK,  64'd8);
    prog[34] = mk(5'd0,  5'd5,  5'd0,  12'd2,   C_SUBIP, 64'd10);
    prog[35] = mk(5'd0,  5'd1,  5'd5,  12'd0,   C_SUBP,  64'hFFFF_FFFF_FFFF_FFFB);

    for (int i = 0; i < 256; i++) dut.imem_q[i] = 32'd0;
    for (int i = 0; i < NPROG; i++) dut.imem_q[i] = enc(prog[i]);

    for (int i = 0; i < NPROG; i++) begin
      if (i == 9) begin
        step(nowrite(prog[9]), 1'b0, 1'b0);
        step(nowrite(prog[9]), 1'b0, 1'b0);
      end
      // Last instruction also asserts reset together with load_pc.
      step(prog[i], 1'b1, (i == NPROG - 1));
    end
    step(nowrite(prog[0]), 1'b1, 1'b0);
    step(nowrite(prog[1]), 1'b1, 1'b0);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
